bf2_bundle_pipe: RTL
====================

# bf2_bundle_pipe

Parametrised radix-2 butterfly bundle with valid/ready flow control, per-beat scaling and bypass, for the pipelined FFT datapath. It processes LANES complex sample pairs (R and Q components) per beat and produces sum and difference outputs one bit wider than the inputs. It replaces free-running enable-gated butterfly registers in stages that need backpressure, per-stage /2 scaling, or stage bypass. A two-entry output buffer (main plus skid) keeps full throughput under backpressure with a registered `in_ready`.

## Interface
- `WIDTH`, 15, input sample width (signed two's complement); outputs are WIDTH+1
- `LANES`, 4, number of parallel butterflies per beat
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous assert, active-high
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  block accepts beat this cycle
- `in_scale`  in  1  1 = divide results by 2 with rounding (per beat)
- `in_bypass`  in  1  1 = pass-through, no butterfly (per beat)
- `in_last`  in  1  frame-end tag, carried with beat
- `din_R_1`, `din_R_2`, `din_Q_1`, `din_Q_2`  in  signed [WIDTH-1:0] x LANES  operands a (…_1) and b (…_2)
- `out_valid`  out  1  output beat present
- `out_ready`  in  1  downstream accepts beat
- `out_last`  out  1  tag of the presented beat
- `dout_R_add`, `dout_R_sub`, `dout_Q_add`, `dout_Q_sub`  out  signed [WIDTH:0] x LANES  results

## Operation
- Per lane, R and Q computed identically; a = …_1, b = …_2.
- Normal (`bypass`=0, `scale`=0): add = a+b, sub = a−b, both in WIDTH+1 bits. No overflow is possible.
- Scaled (`bypass`=0, `scale`=1): add = (a+b+1)>>>1 and sub = (a−b+1)>>>1.
  - Intermediate is WIDTH+2 bits, arithmetic shift, so rounding is round-half-up.
  - Result is sign-extended to WIDTH+1.
- Bypass (`bypass`=1): add = sext(a), sub = sext(b); `scale` is ignored.
- Results are computed combinationally from the input beat and captured on acceptance. `last` travels with its beat.
- Storage: main register M (drives outputs, flag mv) and skid register S (flag sv).
  - `in_ready` = !sv, taken from a register. It is held at 0 while `rst` is high.
  - `out_valid` = mv. Outputs always show M.
  - Accept = in_valid & in_ready. Drain = mv & out_ready.
  - M is free when !mv or Drain.
  - M free and sv: M ← S, sv cleared. If Accept in the same cycle, the new beat goes to S (sv stays 1).
  - M free and !sv: M ← accepted beat. If there is no Accept, mv ← 0.
  - M not free and Accept: S ← beat, sv ← 1.
- Beats are never dropped, duplicated or reordered.
- Output data is held stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, all dout = 0. `in_ready`=0 during reset and 1 from the first clock after release. mv and sv = 0.
- Reset asserted mid-stream clears M and S immediately. In-flight beats are discarded.
- Latency: a beat accepted at edge N appears on the outputs after edge N (one cycle) when M is free.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure:
  - The first stalled cycle absorbs one more beat into S.
  - `in_ready` falls on the edge after S fills.
  - `in_ready` rises on the edge after S drains into M.
- Simultaneous Accept and Drain with sv=1: S moves to M and the new beat enters S. Occupancy is unchanged.
- Changing `in_scale` or `in_bypass` between beats takes effect exactly on the beat it accompanies.

## Test plan
- Reset, then a single beat with a=3, b=2 on all lanes, R and Q, scale=0, out_ready=1. Required: one cycle later out_valid=1, add=5, sub=1, then out_valid=0.
- Scale=1, a=3, b=2 gives add=3, sub=1. a=−3, b=−2 gives add=−2, sub=0. a=16383, b=16383 (WIDTH=15) gives add=16383, sub=0.
- Extremes with scale=0: a=−16384, b=−16384 gives add=−32768. a=16383, b=−16384 gives sub=32767. No wrap.
- Bypass=1, scale=1, a=−5, b=7 gives add=−5 and sub=7 (sign-extended). The next beat with bypass=0 computes normally.
- Stream 8 beats with tags 0..7 and last on beat 7, toggling out_ready in the pattern 1,0,0,1,0,1,1,1. Required:
  - Outputs arrive in order with no loss.
  - in_ready drops only after two beats are held.
  - Data is stable during stalls.
  - out_last is on beat 7 only.
- Assert rst while S and M are both full. Required: out_valid and all dout go to 0 asynchronously, and in_ready=0. After release, the first new beat emerges one cycle after acceptance.

Source files
------------

// File: rtl/bf2_bundle_pipe_if.sv
// rtl/bf2_bundle_pipe_if.sv - input/output beat handshake bundle for the butterfly pipe
interface bf2_bundle_pipe_if #(
  parameter int WIDTH = 15,
  parameter int LANES = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_scale;
  logic                        in_bypass;
  logic                        in_last;
  logic [LANES-1:0][WIDTH-1:0] din_R_1;
  logic [LANES-1:0][WIDTH-1:0] din_R_2;
  logic [LANES-1:0][WIDTH-1:0] din_Q_1;
  logic [LANES-1:0][WIDTH-1:0] din_Q_2;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;
  logic [LANES-1:0][WIDTH:0]   dout_R_add;
  logic [LANES-1:0][WIDTH:0]   dout_R_sub;
  logic [LANES-1:0][WIDTH:0]   dout_Q_add;
  logic [LANES-1:0][WIDTH:0]   dout_Q_sub;

  modport master (
    output in_valid, in_scale, in_bypass, in_last,
    output din_R_1, din_R_2, din_Q_1, din_Q_2,
    output out_ready,
    input  in_ready, out_valid, out_last,
    input  dout_R_add, dout_R_sub, dout_Q_add, dout_Q_sub
  );

  modport slave (
    input  in_valid, in_scale, in_bypass, in_last,
    input  din_R_1, din_R_2, din_Q_1, din_Q_2,
    input  out_ready,
    output in_ready, out_valid, out_last,
    output dout_R_add, dout_R_sub, dout_Q_add, dout_Q_sub
  );
endinterface

// File: rtl/bf2_bundle_pipe.sv
// rtl/bf2_bundle_pipe.sv - radix-2 butterfly bundle with scale/bypass and main+skid output buffer
module bf2_bundle_pipe #(
  parameter int WIDTH = 15,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  bf2_bundle_pipe_if.slave bus
);

  typedef logic [LANES-1:0][WIDTH:0] lane_vec_t;

  typedef struct packed {
    logic      last;
    lane_vec_t r_add;
    lane_vec_t r_sub;
    lane_vec_t q_add;
    lane_vec_t q_sub;
  } beat_t;

  localparam logic signed [WIDTH+1:0] RND = (WIDTH+2)'(1);

  // Two guard bits so the +1 rounding term can never overflow before the shift.
  function automatic logic [2*WIDTH+1:0] bfly(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             scale,
    input logic             bypass
  );
    logic signed [WIDTH+1:0] ax;
    logic signed [WIDTH+1:0] bx;
    logic signed [WIDTH+1:0] s;
    logic signed [WIDTH+1:0] d;
    ax = {{2{a[WIDTH-1]}}, a};
    bx = {{2{b[WIDTH-1]}}, b};
    s  = ax + bx;
    d  = ax - bx;
    if (scale) begin
      s = (s + RND) >>> 1;
      d = (d + RND) >>> 1;
    end
    if (bypass) begin
      return {ax[WIDTH:0], bx[WIDTH:0]};
    end
    return {s[WIDTH:0], d[WIDTH:0]};
  endfunction

  beat_t beat_in;
  beat_t m_q, m_d;
  beat_t s_q, s_d;
  logic  mv_q, mv_d;
  logic  sv_q, sv_d;
  logic  in_ready_q, in_ready_d;
  logic  accept;
  logic  drain;
  logic  m_free;

  always_comb begin
    beat_in      = '0;
    beat_in.last = bus.in_last;
    for (int l = 0; l < LANES; l++) begin
      {beat_in.r_add[l], beat_in.r_sub[l]} =
        bfly(bus.din_R_1[l], bus.din_R_2[l], bus.in_scale, bus.in_bypass);
      {beat_in.q_add[l], beat_in.q_sub[l]} =
        bfly(bus.din_Q_1[l], bus.din_Q_2[l], bus.in_scale, bus.in_bypass);
    end
  end

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = mv_q & bus.out_ready;
  assign m_free = ~mv_q | drain;

  always_comb begin
    m_d  = m_q;
    s_d  = s_q;
    mv_d = mv_q;
    sv_d = sv_q;
    if (m_free) begin
      if (sv_q) begin
        // Skid content is older than any new beat, so it always goes first.
        m_d  = s_q;
        mv_d = 1'b1;
        if (accept) begin
          s_d = beat_in;
        end else begin
          sv_d = 1'b0;
        end
      end else if (accept) begin
        m_d  = beat_in;
        mv_d = 1'b1;
      end else begin
        mv_d = 1'b0;
      end
    end else if (accept) begin
      s_d  = beat_in;
      sv_d = 1'b1;
    end
    in_ready_d = ~sv_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q        <= '0;
      s_q        <= '0;
      mv_q       <= 1'b0;
      sv_q       <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      mv_q       <= mv_d;
      sv_q       <= sv_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = mv_q;
  assign bus.out_last   = m_q.last;
  assign bus.dout_R_add = m_q.r_add;
  assign bus.dout_R_sub = m_q.r_sub;
  assign bus.dout_Q_add = m_q.q_add;
  assign bus.dout_Q_sub = m_q.q_sub;

endmodule
